// File: rtl/wb_sram_slave.sv
// Wishbone slave in front of a byte-writable SRAM: classic and incrementing-burst
// cycles, linear or wrapping bursts, optional wait states before the first beat.
module wb_sram_slave #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int WAIT_STATES    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    output logic                       ACK,
    output logic                       ERR
);

    localparam int BYTES = WB_DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int DEPTH = 2 ** MEM_WORDS_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CLASSIC_ACK,
        ST_BURST
    } state_t;

    state_t                    state;
    logic [3:0]                wait_cnt;
    logic [WB_ADDR_WIDTH-1:0]  addr;       // current word index, not byte address
    logic [WB_ADDR_WIDTH-1:0]  next_addr;
    logic [WB_ADDR_WIDTH-1:0]  wrap_mask;
    logic [MEM_WORDS_LOG2-1:0] mem_idx;
    logic                      req;
    logic                      out_of_range;
    logic                      xfer_state;
    state_t                    first_state;
    logic [WB_DATA_WIDTH-1:0]  mem [DEPTH];

    assign req          = CYC & STB;
    assign mem_idx      = addr[MEM_WORDS_LOG2-1:0];
    assign out_of_range = |addr[WB_ADDR_WIDTH-1:MEM_WORDS_LOG2];
    assign xfer_state   = (state == ST_CLASSIC_ACK) || (state == ST_BURST);
    assign first_state  = (CTI == 3'b010) ? ST_BURST : ST_CLASSIC_ACK;

    // Handshake outputs follow STB within the beat so a burst can stall per cycle.
    assign ACK   = xfer_state & req & ~out_of_range;
    assign ERR   = xfer_state & req & out_of_range;
    assign DAT_R = (ACK && !WE) ? mem[mem_idx] : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wrap_mask = '1;
        case (BTE)
            2'b01:   wrap_mask = WB_ADDR_WIDTH'(3);
            2'b10:   wrap_mask = WB_ADDR_WIDTH'(7);
            2'b11:   wrap_mask = WB_ADDR_WIDTH'(15);
            default: wrap_mask = '1;
        endcase
        next_addr = (addr & ~wrap_mask) | ((addr + WB_ADDR_WIDTH'(1)) & wrap_mask);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr <= ADR >> OFF;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= first_state;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!CYC)
                        state <= ST_IDLE;
                    else if (wait_cnt == 4'd0)
                        state <= first_state;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ST_CLASSIC_ACK: state <= ST_IDLE;
                ST_BURST: begin
                    if (!CYC || ERR)
                        state <= ST_IDLE;
                    else if (ACK) begin
                        if (CTI == 3'b111)
                            state <= ST_IDLE;
                        else
                            addr <= next_addr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ACK && WE && !rst) begin
            for (int b = 0; b < BYTES; b++) begin
                if (SEL[b])
                    mem[mem_idx][8*b +: 8] <= DAT_W[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: a zero-wait and a three-wait-state instance
// share the bus signals; CYC selects which one is being addressed.
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    bit          use3;

    logic        cyc0, cyc3;
    logic [31:0] dat_r0, dat_r3, dr_s;
    logic        ack0, err0, ack3, err3, ack_s, err_s;

    int n_vec;
    int n_bad;

    assign cyc0  = cyc & ~use3;
    assign cyc3  = cyc & use3;
    assign ack_s = use3 ? ack3 : ack0;
    assign err_s = use3 ? err3 : err0;
    assign dr_s  = use3 ? dat_r3 : dat_r0;

    always #5 clk = ~clk;

    wb_sram_slave #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r0),
        .CYC(cyc0), .STB(stb), .WE(we), .SEL(sel), .CTI(cti), .BTE(bte),
        .ACK(ack0), .ERR(err0)
    );

    wb_sram_slave #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS_LOG2(6), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r3),
        .CYC(cyc3), .STB(stb), .WE(we), .SEL(sel), .CTI(cti), .BTE(bte),
        .ACK(ack3), .ERR(err3)
    );

    typedef struct {
        bit          wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          e_ack;
        bit          e_err;
        logic [31:0] e_rd;
    } vec_t;

    // Reference memory, keyed per instance; words never written are absent.
    logic [31:0] mdl [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int cur_ws();
        return use3 ? 3 : 0;
    endfunction

    function automatic int cur_depth();
        return use3 ? 64 : 1024;
    endfunction

    function automatic int key(input int idx);
        return use3 ? idx + 32'h0010_0000 : idx;
    endfunction

    function automatic void mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mdl.exists(key(idx)) ? mdl[key(idx)] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[key(idx)] = w;
    endfunction

    function automatic logic [31:0] mdl_read(input int idx);
        return mdl.exists(key(idx)) ? mdl[key(idx)] : 32'hx;
    endfunction

    // Word visited on beat k of a burst: linear, or wrapping inside an aligned block.
    function automatic int burst_idx(input int start, input logic [1:0] bt, input int k);
        int n;
        if (bt == 2'b00) return start + k;
        n = 2 << bt;
        return (start - start % n) + (start % n + k) % n;
    endfunction

    function automatic vec_t mkv(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input bit ea, input bit ee, input logic [31:0] er);
        vec_t v;
        v.wr = wr; v.adr = a; v.dat = d; v.sel = s; v.e_ack = ea; v.e_err = ee; v.e_rd = er;
        return v;
    endfunction

    task automatic classic(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic g_ack, output logic g_err, output logic [31:0] rd,
                           output int lat, output logic tail);
        @(posedge clk); #1;
        adr = a; dat_w = d; sel = s; we = wr; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        lat = 0; g_ack = 1'b0; g_err = 1'b0; rd = '0;
        while (lat < 40 && !(g_ack || g_err)) begin
            @(negedge clk);
            lat++;
            g_ack = ack_s; g_err = err_s; rd = dr_s;
        end
        // STB is still high here: a correct slave has already gone back to IDLE.
        @(negedge clk);
        tail = ack_s | err_s;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic classic_check(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input bit e_ack, input bit e_err, input logic [31:0] e_rd, input string tag);
        logic g_ack, g_err, tail;
        logic [31:0] rd;
        int lat;
        classic(wr, a, d, s, g_ack, g_err, rd, lat, tail);
        check({tag, " ack"}, 64'(g_ack), 64'(e_ack));
        check({tag, " err"}, 64'(g_err), 64'(e_err));
        check({tag, " latency"}, 64'(lat), 64'(1 + cur_ws()));
        check({tag, " dat_r"}, 64'(rd), 64'(e_rd));
        check({tag, " single pulse"}, 64'(tail), 64'(0));
        if (wr && e_ack) mdl_write(int'(a >> 2), d, s);
    endtask

    task automatic model_classic(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input string tag);
        int idx;
        bit oor;
        logic [31:0] e_rd;
        idx  = int'(a >> 2);
        oor  = idx >= cur_depth();
        e_rd = (!wr && !oor) ? mdl_read(idx) : 32'h0;
        classic_check(wr, a, d, s, !oor, oor, e_rd, tag);
    endtask

    task automatic run_burst(input bit wr, input int start, input logic [1:0] bt, input int beats,
                             input int gap_at, input int gap_len, input int rst_at, input string tag);
        int lat, idx;
        bit done, aborted;
        @(posedge clk); #1;
        we = wr; bte = bt; sel = 4'hF; adr = 32'(start) << 2; dat_w = $urandom;
        cti = (beats == 1) ? 3'b111 : 3'b010; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (lat < 40 && !(ack_s || err_s));
        check({tag, " first latency"}, 64'(lat), 64'(1 + cur_ws()));
        if (!(ack_s || err_s)) begin
            cyc = 1'b0; stb = 1'b0;
            return;
        end
        done = 0; aborted = 0;
        for (int k = 0; k < beats && !done; k++) begin
            idx = burst_idx(start, bt, k);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, " ack after rst"}, 64'(ack_s), 64'(0));
                rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
                done = 1; aborted = 1;
            end else if (idx >= cur_depth()) begin
                check({tag, " oor err"}, 64'(err_s), 64'(1));
                check({tag, " oor ack"}, 64'(ack_s), 64'(0));
                done = 1;
            end else begin
                check({tag, " beat ack"}, 64'(ack_s), 64'(1));
                check({tag, " beat err"}, 64'(err_s), 64'(0));
                check({tag, " beat dat_r"}, 64'(dr_s), wr ? 64'(0) : 64'(mdl_read(idx)));
                if (wr) mdl_write(idx, dat_w, 4'hF);
                if (k == beats - 1) begin
                    done = 1;
                end else begin
                    @(posedge clk); #1;
                    if (k == gap_at) begin
                        stb = 1'b0;
                        for (int g = 0; g < gap_len; g++) begin
                            @(negedge clk);
                            check({tag, " gap ack"}, 64'(ack_s), 64'(0));
                            @(posedge clk); #1;
                        end
                        stb = 1'b1;
                    end
                    dat_w = $urandom;
                    adr   = 32'(burst_idx(start, bt, k + 1)) << 2;
                    cti   = (k + 1 == beats - 1) ? 3'b111 : 3'b010;
                    @(negedge clk);
                end
            end
        end
        if (!aborted) begin
            @(negedge clk);
            check({tag, " idle after"}, 64'(ack_s | err_s), 64'(0));
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
    endtask

    vec_t vt [20];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          r_wr;
        logic [1:0]  r_bt;
        int          r_sel, r_beats, r_start, r_gap;

        n_vec = 0; n_bad = 0; use3 = 0;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0; dat_w = '0;
        sel = 4'hF; cti = 3'b000; bte = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", 64'(ack0), 64'(0));
        check("reset err", 64'(err0), 64'(0));
        check("reset dat_r", 64'(dat_r0), 64'(0));
        check("reset ack ws3", 64'(ack3), 64'(0));
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        vt[0]  = mkv(1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0);
        vt[1]  = mkv(0, 32'h0000_0040, 32'h0,         4'hF, 1, 0, 32'hDEAD_BEEF);
        vt[2]  = mkv(0, 32'h0000_0043, 32'h0,         4'hF, 1, 0, 32'hDEAD_BEEF);
        vt[3]  = mkv(1, 32'h0000_0080, 32'h1122_3344, 4'hF, 1, 0, 32'h0);
        vt[4]  = mkv(1, 32'h0000_0080, 32'hAABB_CCDD, 4'h5, 1, 0, 32'h0);
        vt[5]  = mkv(0, 32'h0000_0080, 32'h0,         4'hF, 1, 0, 32'h11BB_33DD);
        vt[6]  = mkv(1, 32'h0000_0084, 32'h1234_5678, 4'hF, 1, 0, 32'h0);
        vt[7]  = mkv(1, 32'h0000_0084, 32'hFFFF_FFFF, 4'h0, 1, 0, 32'h0);
        vt[8]  = mkv(0, 32'h0000_0084, 32'h0,         4'hF, 1, 0, 32'h1234_5678);
        vt[9]  = mkv(1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1, 0, 32'h0);
        vt[10] = mkv(1, 32'h0000_1000, 32'h0BAD_BAD0, 4'hF, 0, 1, 32'h0);
        vt[11] = mkv(0, 32'h0000_1000, 32'h0,         4'hF, 0, 1, 32'h0);
        vt[12] = mkv(0, 32'h0000_0000, 32'h0,         4'hF, 1, 0, 32'hCAFE_F00D);
        vt[13] = mkv(1, 32'h0000_0FFC, 32'h0F0F_0F0F, 4'hF, 1, 0, 32'h0);
        vt[14] = mkv(0, 32'h0000_0FFC, 32'h0,         4'hF, 1, 0, 32'h0F0F_0F0F);
        vt[15] = mkv(1, 32'h0000_0010, 32'hA000_0004, 4'hF, 1, 0, 32'h0);
        vt[16] = mkv(1, 32'h0000_0014, 32'hA000_0005, 4'hF, 1, 0, 32'h0);
        vt[17] = mkv(1, 32'h0000_0018, 32'hA000_0006, 4'hF, 1, 0, 32'h0);
        vt[18] = mkv(1, 32'h0000_001C, 32'hA000_0007, 4'hF, 1, 0, 32'h0);
        vt[19] = mkv(0, 32'h001F_FFFC, 32'h0,         4'hF, 0, 1, 32'h0);
        for (int i = 0; i < 20; i++)
            classic_check(vt[i].wr, vt[i].adr, vt[i].dat, vt[i].sel,
                          vt[i].e_ack, vt[i].e_err, vt[i].e_rd, $sformatf("vec%0d", i));

        // Words 4..7 hold A0000004..7, so this must return 6,7,4,5.
        run_burst(0, 6, 2'b01, 4, -1, 0, -1, "wrap4 rd");

        run_burst(1, 32, 2'b00, 8, -1, 0, -1, "prefill 32");
        run_burst(1, 32, 2'b00, 8, -1, 0, 2, "rst burst");
        for (int w = 32; w < 40; w++)
            model_classic(0, 32'(w) << 2, 32'h0, 4'hF, $sformatf("after rst w%0d", w));

        run_burst(1, 1022, 2'b00, 4, -1, 0, -1, "oor burst");
        model_classic(0, 32'h0, 32'h0, 4'hF, "oor alias w0");
        model_classic(0, 32'h0FF8, 32'h0, 4'hF, "oor w1022");
        model_classic(0, 32'h0FFC, 32'h0, 4'hF, "oor w1023");

        use3 = 1;
        model_classic(1, 32'h50, 32'h5A5A_1234, 4'hF, "ws3 wr");
        model_classic(0, 32'h50, 32'h0, 4'hF, "ws3 rd");
        model_classic(0, 32'h100, 32'h0, 4'hF, "ws3 oor");
        run_burst(1, 8, 2'b00, 8, 2, 2, -1, "ws3 burst wr");
        run_burst(0, 8, 2'b00, 8, 3, 2, -1, "ws3 burst rd");
        run_burst(0, 13, 2'b10, 8, 1, 2, -1, "ws3 wrap8 rd");

        use3 = 0;
        for (int b = 0; b < 4; b++)
            run_burst(1, 256 + 16 * b, 2'b00, 16, -1, 0, -1, "prefill region");
        for (int i = 0; i < 150; i++) begin
            r_sel = int'($urandom_range(0, 15));
            r_wr  = 1'($urandom_range(0, 1));
            if (r_sel < 5) begin
                r_bt    = 2'($urandom_range(0, 3));
                r_beats = int'($urandom_range(2, 8));
                r_start = (r_bt == 2'b00) ? int'($urandom_range(256, 320 - r_beats))
                                          : int'($urandom_range(256, 319));
                r_gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_beats - 2)) : -1;
                run_burst(r_wr, r_start, r_bt, r_beats, r_gap, int'($urandom_range(1, 3)), -1, "rand burst");
            end else if (r_sel == 15) begin
                model_classic(r_wr, 32'(1024 + $urandom_range(0, 3000)) << 2, $urandom, 4'hF, "rand oor");
            end else begin
                model_classic(r_wr, (32'(256 + $urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3)),
                              $urandom, 4'($urandom_range(0, 15)), "rand classic");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
